// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, ALU-op and state encodings for the multicycle MIPS-subset controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpHalt = 6'b111111;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMem, StWriteback, StHalted, StFault
  } state_e;

  typedef enum logic [2:0] {
    ClsR, ClsLw, ClsSw, ClsAddi, ClsBeq, ClsJ, ClsHalt
  } instr_cls_e;

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Opcode classifier: maps IR[31:26] to an instruction class, flagging unknown opcodes.
module mc_decode import mips_ctrl_pkg::*; (
  input  logic [5:0] opcode,
  output instr_cls_e cls,
  output logic       illegal
);

  always_comb begin
    cls     = ClsR;
    illegal = 1'b0;
    case (opcode)
      OpR:     cls = ClsR;
      OpLw:    cls = ClsLw;
      OpSw:    cls = ClsSw;
      OpAddi:  cls = ClsAddi;
      OpBeq:   cls = ClsBeq;
      OpJ:     cls = ClsJ;
      OpHalt:  cls = ClsHalt;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback sequencing, PC update,
// memory-wait timeout and retired-instruction counter.
module multicycle_controller import mips_ctrl_pkg::*; #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        ir_load,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        reg_dest,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  localparam logic [7:0] LastWait = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, retired_q, pc_plus4;
  logic [7:0]  wait_q, wait_d;
  logic        retire;
  instr_cls_e  cls;
  logic        illegal;

  mc_decode u_decode (
    .opcode  (ir_q[31:26]),
    .cls     (cls),
    .illegal (illegal)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign busy     = !(state_q inside {StIdle, StHalted, StFault});
  assign halted   = (state_q == StHalted);
  assign fault    = (state_q == StFault);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wait_d     = '0;
    retire     = 1'b0;
    ir_load    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_dest   = 1'b0;
    alu_op     = AluAdd;
    case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        ir_load = 1'b1;
        ir_d    = instr;
        state_d = StDecode;
      end
      StDecode: begin
        if (illegal)             state_d = StFault;
        else if (cls == ClsHalt) state_d = StHalted;
        else                     state_d = StExecute;
      end
      StExecute: begin
        alu_src = cls inside {ClsLw, ClsSw, ClsAddi};
        if (cls == ClsR)        alu_op = AluFunct;
        else if (cls == ClsBeq) alu_op = AluSub;
        case (cls)
          ClsLw, ClsSw: state_d = StMem;
          ClsBeq: begin
            state_d = StFetch;
            retire  = 1'b1;
            pc_d    = alu_zero ? branch_target(pc_plus4, ir_q[15:0]) : pc_plus4;
          end
          ClsJ: begin
            state_d = StFetch;
            retire  = 1'b1;
            pc_d    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
          end
          default: state_d = StWriteback;
        endcase
      end
      StMem: begin
        mem_read  = (cls == ClsLw);
        mem_write = (cls == ClsSw);
        if (mem_ready) begin
          if (cls == ClsLw) begin
            state_d = StWriteback;
          end else begin
            state_d = StFetch;
            pc_d    = pc_plus4;
            retire  = 1'b1;
          end
        end else if (wait_q == LastWait) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWriteback: begin
        reg_write  = 1'b1;
        reg_dest   = (cls == ClsR);
        mem_to_reg = (cls == ClsLw);
        pc_d       = pc_plus4;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      default: ;  // HALTED and FAULT are sticky until reset
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus queues the expected per-instruction profile, a negedge monitor
// pops and compares whenever an instruction retires or the core halts/faults.
module tb_multicycle_controller;

  localparam int EvRetire = 1;
  localparam int EvHalt   = 2;
  localparam int EvFault  = 3;
  localparam logic [31:0] InsHalt = 32'hFC00_0000;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] ret;
    int          cyc;
    int          rd;
    int          wr;
    int          rw;
    bit          rdst;
    bit          m2r;
    logic [1:0]  aop;
    bit          src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, alu_zero, mem_ready;
  logic [31:0] instr, pc, retired;
  logic        ir_load, mem_read, mem_write, reg_write, mem_to_reg, alu_src, reg_dest;
  logic        busy, halted, fault;
  logic [1:0]  alu_op;

  logic [31:0] imem [64];
  exp_t        sb[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          ready_lw = 0;
  int          ready_sw = 0;
  int          mem_cnt  = 0;
  bit          stray_ready = 1'b0;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .ir_load    (ir_load),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .reg_dest   (reg_dest),
    .alu_op     (alu_op),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  assign instr    = imem[pc[7:2]];
  assign alu_zero = (pc == 32'h8);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] outs_vec();
    return {22'b0, busy, ir_load, mem_read, mem_write, reg_write, mem_to_reg, alu_src,
            reg_dest, alu_op};
  endfunction

  // Memory model: ready after N strobe cycles (0 = never); optional stray ready elsewhere.
  always @(negedge clk) begin
    int lim;
    if (mem_read || mem_write) begin
      mem_cnt   = mem_cnt + 1;
      lim       = mem_read ? ready_lw : ready_sw;
      mem_ready = (lim != 0) && (mem_cnt == lim);
    end else begin
      mem_cnt   = 0;
      mem_ready = stray_ready;
    end
  end

  // Monitor
  int          a_cyc, a_rd, a_wr, a_irl, a_rw;
  bit          a_rdst, a_m2r, a_src;
  logic [1:0]  a_aop;
  logic [31:0] prev_ret;
  bit          prev_halt, prev_fault;

  always @(negedge clk) begin
    int   ev;
    exp_t e;
    if (rst) begin
      ev = 0;
      {a_cyc, a_rd, a_wr, a_irl, a_rw} = '0;
      {a_rdst, a_m2r, a_src, a_aop}    = '0;
    end else begin
      ev = 0;
      if (retired != prev_ret)        ev = EvRetire;
      else if (halted && !prev_halt)  ev = EvHalt;
      else if (fault && !prev_fault)  ev = EvFault;
      if (ev != 0) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'(ev), 32'd0);
        end else begin
          e = sb.pop_front();
          check("event_kind", 32'(ev), 32'(e.kind));
          check("pc", pc, e.pc);
          check("retired", retired, e.ret);
          check("cycles", 32'(a_cyc), 32'(e.cyc));
          check("mem_read_cycles", 32'(a_rd), 32'(e.rd));
          check("mem_write_cycles", 32'(a_wr), 32'(e.wr));
          check("ctrl_profile", {8'(a_irl), 8'(a_rw), 11'b0, a_rdst, a_m2r, a_aop, a_src},
                {8'd1, 8'(e.rw), 11'b0, e.rdst, e.m2r, e.aop, e.src});
          if (ev != EvRetire) check("stopped_outputs_zero", outs_vec(), 32'd0);
        end
        {a_cyc, a_rd, a_wr, a_irl, a_rw} = '0;
        {a_rdst, a_m2r, a_src, a_aop}    = '0;
      end
      a_cyc  += int'(busy);
      a_rd   += int'(mem_read);
      a_wr   += int'(mem_write);
      a_irl  += int'(ir_load);
      a_rw   += int'(reg_write);
      a_rdst |= reg_dest;
      a_m2r  |= mem_to_reg;
      a_src  |= alu_src;
      a_aop  |= alu_op;
    end
    prev_ret   = retired;
    prev_halt  = halted;
    prev_fault = fault;
  end

  task automatic push(input int kind, input logic [31:0] epc, input logic [31:0] eret,
                      input int cyc, input int rd, input int wr, input int rw,
                      input bit rdst, input bit m2r, input logic [1:0] aop, input bit src);
    exp_t e;
    e = '{kind, epc, eret, cyc, rd, wr, rw, rdst, m2r, aop, src};
    sb.push_back(e);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 64; i++) imem[i] = InsHalt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
    fill_halt();
    repeat (3) @(negedge clk);
    check("reset_pc", pc, 32'h0);
    check("reset_retired", retired, 32'h0);
    check("reset_outputs", outs_vec(), 32'h0);
    check("reset_status", {30'b0, halted, fault}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_without_start", {31'b0, busy}, 32'h0);

    // Program: R, LW, BEQ taken, BEQ not taken, ADDI, J, SW, HALT
    imem[0]  = 32'h012A_4020;
    imem[1]  = 32'h8D09_0004;
    imem[2]  = 32'h1000_0003;
    imem[6]  = 32'h1000_0003;
    imem[7]  = 32'h2129_0001;
    imem[8]  = 32'h0800_0010;
    imem[16] = 32'hAD09_0008;
    push(EvRetire, 32'h04, 1, 4, 0, 0, 1, 1, 0, 2'b10, 0);
    push(EvRetire, 32'h08, 2, 7, 3, 0, 1, 0, 1, 2'b00, 1);
    push(EvRetire, 32'h18, 3, 3, 0, 0, 0, 0, 0, 2'b01, 0);
    push(EvRetire, 32'h1C, 4, 3, 0, 0, 0, 0, 0, 2'b01, 0);
    push(EvRetire, 32'h20, 5, 4, 0, 0, 1, 0, 0, 2'b00, 1);
    push(EvRetire, 32'h40, 6, 3, 0, 0, 0, 0, 0, 2'b00, 0);
    push(EvRetire, 32'h44, 7, 4, 0, 1, 0, 0, 0, 2'b00, 1);
    push(EvHalt,   32'h44, 7, 2, 0, 0, 0, 0, 0, 2'b00, 0);
    stray_ready = 1'b1; ready_lw = 3; ready_sw = 1;
    @(negedge clk);
    start = 1'b1;  // held high: must be ignored outside IDLE
    wait_drain(200, "program_drained");
    repeat (5) @(negedge clk);
    check("halt_sticky", {31'b0, halted}, 32'h1);
    check("halt_pc_held", pc, 32'h44);
    start = 1'b0;
    stray_ready = 1'b0;

    // SW that never completes: timeout after 16 MEM cycles
    do_reset();
    fill_halt();
    imem[0] = 32'hAD09_0008;
    ready_sw = 0;
    push(EvFault, 32'h0, 0, 19, 0, 16, 0, 0, 0, 2'b00, 1);
    pulse_start();
    wait_drain(100, "timeout_drained");
    repeat (3) @(negedge clk);
    check("fault_sticky", {29'b0, fault, mem_write, busy}, 32'h4);

    // Illegal opcode 0x01
    do_reset();
    fill_halt();
    imem[0] = 32'h0400_0000;
    push(EvFault, 32'h0, 0, 2, 0, 0, 0, 0, 0, 2'b00, 0);
    pulse_start();
    wait_drain(50, "illegal_drained");

    // Asynchronous reset while in MEM, then a normal run
    do_reset();
    fill_halt();
    imem[0] = 32'h8D09_0004;
    ready_lw = 0;
    pulse_start();
    n = 0;
    while (!mem_read && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("reached_mem", {31'b0, mem_read}, 32'h1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", outs_vec(), 32'h0);
    check("async_reset_pc", pc, 32'h0);
    check("async_reset_status", {30'b0, halted, fault}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    imem[0] = 32'h012A_4020;
    push(EvRetire, 32'h4, 1, 4, 0, 0, 1, 1, 0, 2'b10, 0);
    push(EvHalt,   32'h4, 1, 2, 0, 0, 0, 0, 0, 2'b00, 0);
    pulse_start();
    wait_drain(50, "post_reset_drained");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, 16, max wait cycles for mem_ready before a fault (range 1..255).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin execution from IDLE.
REQ-006 instr  in  32  word from instruction memory at address pc.
REQ-007 alu_zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  data memory completion strobe.
REQ-009 pc  out  32  current program counter.
REQ-010 ir_load  out  1  instruction register capture strobe.
REQ-011 mem_read, mem_write, reg_write, mem_to_reg, alu_src, reg_dest  out  1 each  datapath controls.
REQ-012 alu_op  out  2  00 add, 01 sub, 10 use funct, 11 reserved.
REQ-013 busy  out  1  high in any state except IDLE, HALTED, FAULT.
REQ-014 halted  out  1  HALTED state.
REQ-015 fault  out  1  FAULT state (illegal opcode or memory timeout).
REQ-016 retired  out  32  count of completed instructions.

Function
REQ-017 States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED, FAULT.
REQ-018 IDLE->FETCH on start=1; start is ignored in every other state.
REQ-019 FETCH SHALL assert ir_load for exactly one cycle, capture instr into internal IR, then go to DECODE.
REQ-020 DECODE SHALL classify IR[31:26]: 000000 R, 100011 LW, 101011 SW, 001000 ADDI, 000100 BEQ, 000010 J, 111111 HALT; any other opcode -> FAULT.
REQ-021 HALT -> HALTED without advancing pc; J, BEQ, others -> EXECUTE.
REQ-022 EXECUTE alu_op: R=10, BEQ=01, LW/SW/ADDI=00; alu_src=1 for LW/SW/ADDI, else 0.
REQ-023 EXECUTE next: LW/SW->MEM, R/ADDI->WRITEBACK, BEQ/J->FETCH.
REQ-024 BEQ: pc <= pc+4+(sext(IR[15:0])<<2) if alu_zero=1 in EXECUTE, else pc+4; J: pc <= {pc_plus4[31:28], IR[25:0], 2'b00}.
REQ-025 MEM SHALL hold mem_read (LW) or mem_write (SW) high until the cycle mem_ready=1; mem_ready outside MEM is ignored.
REQ-026 On mem_ready in MEM: LW->WRITEBACK; SW->FETCH with pc <= pc+4.
REQ-027 MEM wait counter counts cycles in MEM without mem_ready; reaching MEM_TIMEOUT -> FAULT, strobes drop next cycle.
REQ-028 WRITEBACK SHALL assert reg_write for one cycle; reg_dest=1 for R only; mem_to_reg=1 for LW only; pc <= pc+4; next FETCH.
REQ-029 All control outputs SHALL be Moore functions of state and IR; zero in IDLE, HALTED, FAULT.
REQ-030 retired SHALL increment by 1 on the cycle each instruction leaves its final state (not HALT); wraps 2^32-1 -> 0.
REQ-031 Cycle counts: R/ADDI 4, BEQ/J 3, SW 3+wait, LW 4+wait, where wait >= 1 is MEM cycles.
REQ-032 HALTED and FAULT are sticky until rst.
REQ-033 pc arithmetic is modulo 2^32.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, pc=RESET_PC, IR=0, retired=0, wait counter=0, all outputs 0, including mid-MEM.

Structure
REQ-035 Opcode constants, state encoding, and alu_op codes SHALL live in shared package mips_ctrl_pkg.
REQ-036 One combinational sub-module mc_decode SHALL map opcode to instruction class and illegal flag.

Verification
REQ-037 Reset, start, R-type 0x012A4020 -> ir_load, EXECUTE alu_op=10, WRITEBACK reg_write=1 reg_dest=1, pc=4, retired=1 after 4 cycles.
REQ-038 LW 0x8D090004, mem_ready after 3 MEM cycles -> mem_read high 3 cycles, mem_to_reg=1 in WRITEBACK, total 7 cycles, pc=4.
REQ-039 BEQ imm=0x0003 at pc=8: alu_zero=1 -> pc=24; alu_zero=0 -> pc=12.
REQ-040 SW with mem_ready never asserted, MEM_TIMEOUT=16 -> fault=1 after 16 MEM cycles, mem_write=0, busy=0.
REQ-041 Opcode 0x3F -> halted=1, pc unchanged, retired unchanged; opcode 0x01 -> fault=1.
REQ-042 rst pulsed mid-MEM -> all outputs 0, pc=RESET_PC asynchronously; subsequent start runs normally.
